// File: rtl/sram_access_ctrl.sv
// Memory-stage front end sequencing single word accesses to a multi-cycle SRAM,
// holding the pipeline frozen (ready=0) until the access completes.
// Optional build macro MEM_ALIGN_CHECK_EN adds the `misaligned` output and skips
// the SRAM for byte addresses that are not word aligned.
module sram_access_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_BASE    = 1024,
   parameter int SRAM_ADDR_W = 16,
   parameter int WAIT_CYCLES = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   MEM_R_EN,
   input  logic                   MEM_W_EN,
   input  logic [ADDR_W-1:0]      ALU_Res,
   input  logic [DATA_W-1:0]      Val_Rm,
   output logic [DATA_W-1:0]      out,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0]      sram_wdata,
   input  logic [DATA_W-1:0]      sram_rdata,
   output logic                   sram_we_n,
   output logic                   sram_oe_n
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic                   misaligned
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam int          CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   op_wr_q, op_wr_d;
   logic [DATA_W-1:0]      out_q, out_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic                   we_n_q, we_n_d;
   logic                   oe_n_q, oe_n_d;

   logic                   req;
   logic                   skip;
   logic [ADDR_W-1:0]      offset;
   logic [SRAM_ADDR_W-1:0] word_addr;
   logic                   unused_bits;

   assign req       = MEM_R_EN | MEM_W_EN;
   // Unsigned subtract: addresses below MEM_BASE wrap silently.
   assign offset    = ALU_Res - ADDR_W'(MEM_BASE);
   assign word_addr = offset[SRAM_ADDR_W+1:2];
   assign unused_bits = ^{offset[ADDR_W-1:SRAM_ADDR_W+2], offset[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
   logic mis_q, mis_d;
   assign skip       = (ALU_Res[1:0] != 2'b00);
   assign mis_d      = (state_q == IDLE) && req && skip;
   assign misaligned = mis_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mis_q <= 1'b0;
      else      mis_q <= mis_d;
   end
`else
   assign skip = 1'b0;
`endif

   // Ready is forced high during reset so an aborted access never freezes the pipe.
   assign ready = !rst || (state_q == DONE) || ((state_q == IDLE) && !req);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      out_d   = out_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_n_d  = we_n_q;
      oe_n_d  = oe_n_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (skip) begin
                  state_d = DONE;
               end else begin
                  addr_d  = word_addr;
                  wdata_d = Val_Rm;
                  op_wr_d = MEM_W_EN;
                  cnt_d   = CNT_INIT;
                  we_n_d  = !MEM_W_EN;
                  oe_n_d  = MEM_W_EN;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (!op_wr_q) out_d = sram_rdata;
               we_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               state_d = DONE;
            end
         end
         // A request still asserted here belongs to the instruction just retired.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         out_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         out_q   <= out_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_n_q  <= we_n_d;
         oe_n_q  <= oe_n_d;
      end
   end

   assign out        = out_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;
   assign sram_we_n  = we_n_q;
   assign sram_oe_n  = oe_n_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl with a behavioural SRAM attached to its pins.
module tb_sram_access_ctrl;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SAW    = 16;
   localparam int WAIT   = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              MEM_R_EN, MEM_W_EN;
   logic [ADDR_W-1:0] ALU_Res;
   logic [DATA_W-1:0] Val_Rm;
   logic [DATA_W-1:0] out;
   logic              ready;
   logic [SAW-1:0]    sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
   logic              sram_we_n, sram_oe_n;
   logic              mis_sig;

   always #5 clk = ~clk;

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned;
   assign mis_sig = misaligned;
`else
   assign mis_sig = 1'b0;
`endif

   sram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BASE(1024),
                      .SRAM_ADDR_W(SAW), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .out(out), .ready(ready),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
`ifdef MEM_ALIGN_CHECK_EN
      , .misaligned(misaligned)
`endif
   );

   // Behavioural SRAM: write on the clock while we_n is low, asynchronous read.
   logic [DATA_W-1:0] sram [0:65535];
   always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_wdata;
   assign sram_rdata = sram[sram_addr];

   typedef struct {
      int          rdy_low;
      int          we_low;
      int          oe_low;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] dout;
      logic        mis;
      bit          timeout;
   } rec_t;

   rec_t        exp_q[$];
   logic [31:0] ref_mem [logic [15:0]];
   logic [31:0] last_out;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [15:0] word_of(input logic [31:0] a);
      logic [31:0] t;
      t = a - 32'd1024;
      return t[17:2];
   endfunction

   task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      MEM_R_EN = r; MEM_W_EN = w; ALU_Res = a; Val_Rm = d;
   endtask

   // Reference model: push what the access must look like.
   task automatic expect_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      rec_t e;
      e.addr = word_of(a); e.wdata = d; e.mis = 1'b0; e.timeout = 0;
`ifdef MEM_ALIGN_CHECK_EN
      if (a[1:0] != 2'b00) begin
         e.rdy_low = 1; e.we_low = 0; e.oe_low = 0; e.dout = last_out; e.mis = 1'b1;
         exp_q.push_back(e);
         return;
      end
`endif
      e.rdy_low = WAIT + 1;
      if (w) begin
         e.we_low = WAIT; e.oe_low = 0; ref_mem[e.addr] = d;
      end else if (r) begin
         e.we_low = 0; e.oe_low = WAIT; last_out = ref_mem[e.addr];
      end
      e.dout = last_out;
      exp_q.push_back(e);
   endtask

   // Observe one access from its IDLE cycle up to and including the DONE cycle.
   task automatic wait_done(output rec_t o);
      bit fin;
      o.rdy_low = 0; o.we_low = 0; o.oe_low = 0; o.addr = '0; o.wdata = '0;
      o.dout = '0; o.mis = 1'b0; o.timeout = 0;
      fin = 0;
      for (int i = 0; i < 50 && !fin; i++) begin
         @(negedge clk);
         if (!sram_we_n) begin o.we_low++; o.addr = sram_addr; o.wdata = sram_wdata; end
         if (!sram_oe_n) begin o.oe_low++; o.addr = sram_addr; end
         if (ready) begin o.dout = out; o.mis = mis_sig; fin = 1; end
         else o.rdy_low++;
      end
      if (!fin) o.timeout = 1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_req(1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5);
      last_out = '0;
      #12;
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
      n_checks++; if ({sram_we_n, sram_oe_n} !== 2'b11) begin n_fail++; $display("FAIL reset_strobes: got %b expected 11", {sram_we_n, sram_oe_n}); end
      n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out); end
      n_checks++; if ({sram_addr, sram_wdata} !== 48'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", sram_addr, sram_wdata); end
      set_req(1'b0, 1'b0, '0, '0);
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_write();
      rec_t o, e;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
      expect_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
      wait_done(o);
      set_req(1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      n_checks++; if (o.timeout) begin n_fail++; $display("FAIL write_timeout: no DONE within 50 cycles"); end
      n_checks++; if (o.rdy_low !== e.rdy_low) begin n_fail++; $display("FAIL write_ready_low: got %0d expected %0d", o.rdy_low, e.rdy_low); end
      n_checks++; if (o.we_low !== e.we_low || o.oe_low !== e.oe_low) begin n_fail++; $display("FAIL write_strobes: we %0d oe %0d expected we %0d oe %0d", o.we_low, o.oe_low, e.we_low, e.oe_low); end
      n_checks++; if (o.addr !== e.addr || o.wdata !== e.wdata) begin n_fail++; $display("FAIL write_addr_data: got %h/%h expected %h/%h", o.addr, o.wdata, e.addr, e.wdata); end
   endtask

   task automatic test_read();
      rec_t o, e;
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 32'd1032, 32'h0);
      expect_access(1'b1, 1'b0, 32'd1032, 32'h0);
      wait_done(o);
      set_req(1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      n_checks++; if (o.rdy_low !== e.rdy_low) begin n_fail++; $display("FAIL read_ready_low: got %0d expected %0d", o.rdy_low, e.rdy_low); end
      n_checks++; if (o.oe_low !== e.oe_low || o.we_low !== e.we_low) begin n_fail++; $display("FAIL read_strobes: oe %0d we %0d expected oe %0d we %0d", o.oe_low, o.we_low, e.oe_low, e.we_low); end
      n_checks++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL read_addr: got %h expected %h", o.addr, e.addr); end
      n_checks++; if (o.dout !== e.dout) begin n_fail++; $display("FAIL read_out: got %h expected %h", o.dout, e.dout); end
   endtask

   task automatic test_back_to_back();
      rec_t o1, o2, e;
      int bad;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 32'd1024, 32'h11112222);
      expect_access(1'b0, 1'b1, 32'd1024, 32'h11112222);
      wait_done(o1);
      set_req(1'b0, 1'b1, 32'd1028, 32'h33334444);
      expect_access(1'b0, 1'b1, 32'd1028, 32'h33334444);
      wait_done(o2);
      set_req(1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      n_checks++; if (o1.rdy_low !== e.rdy_low || o1.we_low !== e.we_low) begin n_fail++; $display("FAIL b2b_first_timing: ready_low %0d we %0d expected %0d %0d", o1.rdy_low, o1.we_low, e.rdy_low, e.we_low); end
      n_checks++; if (o1.addr !== e.addr || o1.wdata !== e.wdata) begin n_fail++; $display("FAIL b2b_first_addr_data: got %h/%h expected %h/%h", o1.addr, o1.wdata, e.addr, e.wdata); end
      e = exp_q.pop_front();
      n_checks++; if (o2.rdy_low !== e.rdy_low || o2.we_low !== e.we_low) begin n_fail++; $display("FAIL b2b_second_timing: ready_low %0d we %0d expected %0d %0d", o2.rdy_low, o2.we_low, e.rdy_low, e.we_low); end
      n_checks++; if (o2.addr !== e.addr || o2.wdata !== e.wdata) begin n_fail++; $display("FAIL b2b_second_addr_data: got %h/%h expected %h/%h", o2.addr, o2.wdata, e.addr, e.wdata); end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!ready || !sram_we_n || !sram_oe_n) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_no_reissue: got %0d busy cycles expected 0", bad); end
   endtask

   task automatic test_both_enables();
      rec_t o, e;
      @(posedge clk); #1;
      set_req(1'b1, 1'b1, 32'd1028, 32'h12345678);
      expect_access(1'b1, 1'b1, 32'd1028, 32'h12345678);
      wait_done(o);
      set_req(1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      n_checks++; if (o.we_low !== e.we_low || o.oe_low !== e.oe_low) begin n_fail++; $display("FAIL both_strobes: we %0d oe %0d expected we %0d oe %0d", o.we_low, o.oe_low, e.we_low, e.oe_low); end
      n_checks++; if (o.addr !== e.addr || o.wdata !== e.wdata) begin n_fail++; $display("FAIL both_addr_data: got %h/%h expected %h/%h", o.addr, o.wdata, e.addr, e.wdata); end
      n_checks++; if (o.dout !== e.dout) begin n_fail++; $display("FAIL both_out_held: got %h expected %h", o.dout, e.dout); end
   endtask

   task automatic test_misaligned();
      rec_t o, e;
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 32'd1025, 32'h0);
      expect_access(1'b1, 1'b0, 32'd1025, 32'h0);
      wait_done(o);
      set_req(1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      n_checks++; if (o.rdy_low !== e.rdy_low) begin n_fail++; $display("FAIL misalign_ready_low: got %0d expected %0d", o.rdy_low, e.rdy_low); end
      n_checks++; if (o.we_low !== e.we_low || o.oe_low !== e.oe_low) begin n_fail++; $display("FAIL misalign_strobes: we %0d oe %0d expected we %0d oe %0d", o.we_low, o.oe_low, e.we_low, e.oe_low); end
      n_checks++; if (o.dout !== e.dout) begin n_fail++; $display("FAIL misalign_out: got %h expected %h", o.dout, e.dout); end
      n_checks++; if (o.mis !== e.mis) begin n_fail++; $display("FAIL misalign_flag: got %b expected %b", o.mis, e.mis); end
      @(negedge clk);
      n_checks++; if (mis_sig !== 1'b0) begin n_fail++; $display("FAIL misalign_flag_clear: got %b expected 0", mis_sig); end
   endtask

   task automatic test_wrap();
      rec_t o, e;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D);
      expect_access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D);
      wait_done(o);
      set_req(1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      n_checks++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", o.addr, e.addr); end
      n_checks++; if (o.we_low !== e.we_low) begin n_fail++; $display("FAIL wrap_we_low: got %0d expected %0d", o.we_low, e.we_low); end
   endtask

   task automatic test_reset_mid_access();
      rec_t o, e;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 32'd1044, 32'h55AA55AA);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      n_checks++; if ({sram_we_n, sram_oe_n} !== 2'b11) begin n_fail++; $display("FAIL midrst_strobes: got %b expected 11", {sram_we_n, sram_oe_n}); end
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ready); end
      n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL midrst_out: got %h expected 0", out); end
      last_out = '0;
      set_req(1'b0, 1'b0, '0, '0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      n_checks++; if ({ready, sram_we_n, sram_oe_n} !== 3'b111) begin n_fail++; $display("FAIL midrst_idle: got %b expected 111", {ready, sram_we_n, sram_oe_n}); end
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 32'd1032, 32'h0);
      expect_access(1'b1, 1'b0, 32'd1032, 32'h0);
      wait_done(o);
      set_req(1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      n_checks++; if (o.rdy_low !== e.rdy_low || o.oe_low !== e.oe_low) begin n_fail++; $display("FAIL midrst_next_timing: ready_low %0d oe %0d expected %0d %0d", o.rdy_low, o.oe_low, e.rdy_low, e.oe_low); end
      n_checks++; if (o.dout !== e.dout) begin n_fail++; $display("FAIL midrst_next_out: got %h expected %h", o.dout, e.dout); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_both_enables();
      test_misaligned();
      test_wrap();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
